// File: rtl/spi_master_core.sv
// SPI mode-0 master shift engine. SCLK is generated from a half-period
// clock-enable counter so the whole SPI path runs in the clk_in domain.
// Words are sent MSB-first on mosi and received MSB-first from miso.
module spi_master_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 10
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] NBITS    = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  // MSB goes straight from tx_data to mosi, so only the remaining bits are held
  logic [DATA_WIDTH-2:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

  assign tick    = (cnt_q == CNT_LAST);
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

  // State and datapath registers; reset aborts any transfer silently
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; every tick advances one half-period
  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEAD;
          tx_d    = tx_data[DATA_WIDTH-2:0];
          mosi_d  = tx_data[DATA_WIDTH-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      LEAD, LOW: begin
        if (tick) begin
          state_d = HIGH;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
          bit_d   = bit_q + BW'(1);
        end
      end
      HIGH: begin
        if (tick) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q < NBITS) begin
            state_d = LOW;
            mosi_d  = tx_q[DATA_WIDTH-2];
            tx_d    = tx_q << 1;
          end else begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d   = IDLE;
          cnt_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: SPI timing and data are
// predicted from edge-time formulas and the word-level miso source.
module tb_spi_master_core;

  localparam int DW   = 8;
  localparam int DIV  = 10;
  localparam int XFER = (2 * DW + 1) * DIV;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] tx_data;
  logic          busy, done, sclk, mosi, cs_n, miso;
  logic [DW-1:0] rx_data;

  int vectors     = 0;
  int miscompares = 0;

  // miso source: 0 = loopback from mosi, 1 = constant, 2 = word pattern MSB-first
  int            miso_mode;
  logic          miso_const;
  logic [DW-1:0] miso_sh;

  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? miso_const : miso_sh[DW-1];

  spi_master_core #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Request a transfer; returns #1 after the accept edge E0
  task automatic launch(input logic [DW-1:0] tx, input bit hold);
    tx_data = tx;
    start   = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  // Follows one transfer from E0 to E0+XFER and checks timing and data
  task automatic check_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] exp_rx,
                            input bit poke_start, input string tag);
    int            rises  = 0;
    int            cs_low = 0;
    int            dones  = 0;
    logic          prev_sclk;
    logic          prev_mosi;
    logic [DW-1:0] mosi_bits = '0;

    vectors++;
    if (cs_n !== 1'b0 || busy !== 1'b1 || sclk !== 1'b0 || mosi !== tx[DW-1]) begin
      miscompares++;
      $display("FAIL %s accept: cs_n=%b busy=%b sclk=%b mosi=%b want 0 1 0 %b",
               tag, cs_n, busy, sclk, mosi, tx[DW-1]);
    end
    cs_low    = 1;
    prev_sclk = sclk;
    prev_mosi = mosi;
    for (int i = 1; i <= XFER; i++) begin
      if (poke_start && i == 40) begin start = 1'b1; tx_data = '0; end
      if (poke_start && i == 41) start = 1'b0;
      step();
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        vectors++;
        if (i != (2 * rises + 1) * DIV) begin
          miscompares++;
          $display("FAIL %s rise%0d time: got %0d want %0d", tag, rises, i, (2 * rises + 1) * DIV);
        end
        mosi_bits = {mosi_bits[DW-2:0], mosi};
        rises++;
        miso_sh = miso_sh << 1;
      end
      if (sclk === 1'b0 && prev_sclk === 1'b1) begin
        vectors++;
        if (i != 2 * rises * DIV) begin
          miscompares++;
          $display("FAIL %s fall time: got %0d want %0d", tag, i, 2 * rises * DIV);
        end
      end
      if (mosi !== prev_mosi && !(sclk === 1'b0 && prev_sclk === 1'b1) && i != XFER) begin
        vectors++;
        miscompares++;
        $display("FAIL %s mosi change off falling edge at cycle %0d", tag, i);
      end
      if (cs_n === 1'b0) cs_low++;
      if (done === 1'b1) begin
        dones++;
        vectors++;
        if (i != XFER) begin
          miscompares++;
          $display("FAIL %s done time: got %0d want %0d", tag, i, XFER);
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
    end

    vectors++;
    if (cs_low != XFER) begin
      miscompares++;
      $display("FAIL %s cs_n low cycles: got %0d want %0d", tag, cs_low, XFER);
    end
    vectors++;
    if (rises != DW) begin
      miscompares++;
      $display("FAIL %s sclk rises: got %0d want %0d", tag, rises, DW);
    end
    vectors++;
    if (mosi_bits !== tx) begin
      miscompares++;
      $display("FAIL %s mosi bits: got %h want %h", tag, mosi_bits, tx);
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL %s done pulses: got %0d want 1", tag, dones);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end state: done=%b busy=%b cs_n=%b sclk=%b mosi=%b want 1 0 1 0 0",
               tag, done, busy, cs_n, sclk, mosi);
    end
    vectors++;
    if (rx_data !== exp_rx) begin
      miscompares++;
      $display("FAIL %s rx_data: got %h want %h", tag, rx_data, exp_rx);
    end
  endtask

  // Checks that the core sits quietly in its idle state for n cycles
  task automatic idle_quiet(input int n, input logic [DW-1:0] exp_rx, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      vectors++;
      if (sclk !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || rx_data !== exp_rx) begin
        miscompares++;
        $display("FAIL %s idle cycle %0d: sclk=%b cs_n=%b mosi=%b busy=%b done=%b rx=%h want 0 1 0 0 0 %h",
                 tag, i, sclk, cs_n, mosi, busy, done, rx_data, exp_rx);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    idle_quiet(50, '0, "reset");
  endtask

  task automatic test_loopback();
    miso_mode = 0;
    launch(8'hA5, 1'b0);
    check_xfer(8'hA5, 8'hA5, 1'b0, "loopback");
    idle_quiet(3, 8'hA5, "loopback_after");
  endtask

  task automatic test_fixed_miso();
    miso_mode  = 1;
    miso_const = 1'b1;
    launch(8'h3C, 1'b0);
    check_xfer(8'h3C, 8'hFF, 1'b0, "miso_one");
    idle_quiet(3, 8'hFF, "miso_one_after");
    miso_const = 1'b0;
    launch(8'h3C, 1'b0);
    check_xfer(8'h3C, 8'h00, 1'b0, "miso_zero");
    idle_quiet(3, 8'h00, "miso_zero_after");
  endtask

  task automatic test_start_while_busy();
    miso_mode = 0;
    launch(8'hA5, 1'b0);
    check_xfer(8'hA5, 8'hA5, 1'b1, "start_busy");
    idle_quiet(5, 8'hA5, "start_busy_after");
  endtask

  task automatic test_reset_mid();
    miso_mode = 0;
    launch(8'hC3, 1'b0);
    repeat (49) step();
    reset = 1'b1;
    step();
    vectors++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || rx_data !== '0 ||
        mosi !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: cs_n=%b sclk=%b busy=%b rx=%h mosi=%b done=%b want 1 0 0 00 0 0",
               cs_n, sclk, busy, rx_data, mosi, done);
    end
    reset = 1'b0;
    idle_quiet(200, '0, "reset_mid_quiet");
    launch(8'h5A, 1'b0);
    check_xfer(8'h5A, 8'h5A, 1'b0, "reset_mid_restart");
  endtask

  task automatic test_back_to_back();
    miso_mode = 0;
    launch(8'h12, 1'b1);
    check_xfer(8'h12, 8'h12, 1'b0, "b2b_first");
    tx_data = 8'h34;
    step();
    start = 1'b0;
    vectors++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b second accept: cs_n=%b busy=%b want 0 1", cs_n, busy);
    end
    check_xfer(8'h34, 8'h34, 1'b0, "b2b_second");
    idle_quiet(5, 8'h34, "b2b_after");
  endtask

  task automatic test_random();
    logic [DW-1:0] tx, pat, exp_rx;
    for (int n = 0; n < 8; n++) begin
      tx      = DW'($urandom);
      pat     = DW'($urandom);
      miso_mode = (($urandom & 1) == 0) ? 0 : 2;
      miso_sh = pat;
      exp_rx  = (miso_mode == 0) ? tx : pat;
      launch(tx, 1'b0);
      check_xfer(tx, exp_rx, 1'b0, "random");
      idle_quiet(int'($urandom_range(1, 4)), exp_rx, "random_gap");
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    tx_data    = '0;
    miso_mode  = 0;
    miso_const = 1'b0;
    miso_sh    = '0;
    test_reset();
    test_loopback();
    test_fixed_miso();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

SPI mode-0 master shift engine, clocked directly from the 100 MHz system clock. It generates SCLK internally with a clock-enable counter set to the same 5 MHz rate as the divided clock, so the whole SPI path stays in one clock domain. It accepts a parallel word from the controlling logic, shifts it out MSB-first on MOSI, captures MISO, and returns the received word with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 8, bits per transfer (≥2)
- CLK_DIV, 10, clk_in cycles per SCLK half-period (≥2); 10 gives 5 MHz SCLK from 100 MHz
- clk_in  input  1  system clock, 100 MHz. One clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-high
- start  input  1  request a transfer; sampled only in IDLE
- tx_data  input  DATA_WIDTH  word to send; latched on the start-accept edge
- busy  output  1  high from the start-accept edge until the end of the transfer
- done  output  1  one-cycle pulse at the end of the transfer
- rx_data  output  DATA_WIDTH  last received word; updated only on the done edge
- sclk  output  1  SPI clock, CPOL=0
- mosi  output  1  serial data out, MSB first
- miso  input  1  serial data in; no internal synchronizer
- cs_n  output  1  chip select, active-low

## Operation
- States: IDLE, LEAD, HIGH, LOW, TRAIL.
- Half-period counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1. It is cleared on each state entry. A "tick" is the cycle where the count equals CLK_DIV-1.
- Bit counter: width $clog2(DATA_WIDTH+1). It counts the rising SCLK edges issued.
- IDLE, start=1: on that edge, go to LEAD and apply the following.
  - Latch tx_data into the TX shift register.
  - cs_n←0, busy←1, mosi←tx_data[DATA_WIDTH-1], sclk stays 0.
- LEAD, on tick: go to HIGH.
  - sclk←1.
  - Shift the current miso into the RX shift register LSB; the register shifts left.
  - Bit counter +1.
- HIGH, on tick:
  - If bit counter < DATA_WIDTH: go to LOW, sclk←0, mosi←next TX bit.
  - Otherwise: go to TRAIL, sclk←0, mosi holds its value.
- LOW, on tick: go to HIGH, sclk←1, sample miso as in LEAD, bit counter +1.
- TRAIL, on tick: go to IDLE and apply the following.
  - cs_n←1, busy←0, mosi←0.
  - done←1 for one cycle.
  - rx_data←RX shift register.
- start is ignored in every state other than IDLE. tx_data changes during a transfer have no effect.
- Reset on any cycle, including mid-transfer, forces:
  - state IDLE, all counters 0
  - sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0
  - no done pulse for the aborted transfer.

## Timing
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0.
- Start-accept edge is E0. At E0: cs_n falls, busy rises, and the MSB appears on mosi.
- Rising SCLK edges occur at E0 + (2k+1)·CLK_DIV, for k = 0..DATA_WIDTH-1. Falling edges occur at E0 + (2k+2)·CLK_DIV.
- cs_n low and busy high last exactly (2·DATA_WIDTH+1)·CLK_DIV cycles. With the defaults this is 170 cycles.
- done, cs_n↑, busy↓ and rx_data all update on the same edge, E0 + (2·DATA_WIDTH+1)·CLK_DIV.
- Data ordering: mosi changes only on falling-SCLK edges or at E0. miso is sampled only on rising-SCLK edges.
- Back-to-back transfers:
  - start held high across done is accepted on the first cycle after done.
  - cs_n is then high for exactly 1 clk_in cycle.
- Final SCLK edge is a fall, followed by one half-period before cs_n rises. SCLK is therefore always 0 when cs_n toggles.

## Test plan
- Reset: hold reset 3 cycles, then release with start=0 → all outputs at reset values, and they stay there for 50 cycles.
- Loopback: miso driven from mosi, tx_data=8'hA5, 1-cycle start → the following must hold.
  - cs_n low 170 cycles, 8 sclk rising edges.
  - First rise 10 cycles after E0.
  - done 1 cycle at E0+170, rx_data=8'hA5, busy low at E0+170.
- Fixed MISO: miso=1, tx_data=8'h3C → the following must hold.
  - mosi sequence at the rising edges is 0,0,1,1,1,1,0,0.
  - rx_data=8'hFF.
  - A repeat run with miso=0 gives rx_data=8'h00.
- Start while busy: start again at E0+40 with tx_data=8'h00 → it is ignored, the transfer completes with the original 8'hA5, and exactly one done pulse occurs.
- Reset mid-transfer: assert reset at E0+50 → the following must hold.
  - Next edge: cs_n=1, sclk=0, busy=0, rx_data=0.
  - No done pulse.
  - A new start afterwards completes normally.
- Back-to-back: start held high for two transfers (8'h12 then 8'h34, loopback) → the following must hold.
  - Second E0 is one cycle after the first done.
  - cs_n high for exactly 1 cycle between transfers.
  - rx_data is 8'h12 then 8'h34.
